// File: rtl/audio_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sched_pkg
//  Description : Shared types and constants for the audio FIR scheduler:
//                frame-sequencer state encoding, channel select codes and
//                the default codec sample width.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_sched_pkg;

    // Codec sample width used when the instantiating level does not override it
    localparam int c_DW_DEFAULT = 24;

    // Channel select codes presented on eng_ch
    localparam logic c_CH_LEFT  = 1'b0;
    localparam logic c_CH_RIGHT = 1'b1;

    // Frame sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_ST_L    = 3'd2,
        S_WT_L    = 3'd3,
        S_ST_R    = 3'd4,
        S_WT_R    = 3'd5,
        S_WR_WAIT = 3'd6,
        S_WR      = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sched_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sched_timeout_ctr
//  Description : Engine-wait watchdog. Cleared when a channel is started,
//                counts while the scheduler waits for eng_done, and reports
//                expiry once the count reaches TIMEOUT. Saturates at the
//                limit so expiry stays asserted until the next clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sched_timeout_ctr #(
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TW-1:0] c_LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] r_count;

    // Wait-cycle counter: clear has priority, counting stops at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/audio_fir_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : audio_fir_scheduler
//  Description : Moves one stereo frame codec -> shared FIR engine -> codec.
//                Owns the codec read/write handshakes and runs the left then
//                the right sample through a single FIR engine. A missing
//                eng_done forces that channel's result to zero and sets a
//                sticky timeout error. All outputs are registered.
//  Options     : AUD_FIR_SCHED_BYPASS_EN - adds a bypass input; a frame
//                taken with bypass=1 is written back unfiltered and the
//                engine is never started.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_fir_scheduler
    import audio_sched_pkg::*;
#(
    parameter int DW      = c_DW_DEFAULT,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic          clock,
    input  logic          reset,
    // codec input side
    input  logic          read_ready,
    input  logic [DW-1:0] readdata_left,
    input  logic [DW-1:0] readdata_right,
    output logic          read,
    // codec output side
    input  logic          write_ready,
    output logic          write,
    output logic [DW-1:0] writedata_left,
    output logic [DW-1:0] writedata_right,
    // shared FIR engine
    output logic          eng_start,
    output logic          eng_ch,
    output logic [DW-1:0] eng_in,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_out,
`ifdef AUD_FIR_SCHED_BYPASS_EN
    input  logic          bypass,
`endif
    // status
    output logic          busy,
    output logic          timeout_err,
    output logic          overrun
);

    state_t        r_state;
    logic [DW-1:0] r_lat_left;
    logic [DW-1:0] r_lat_right;
    logic [DW-1:0] r_res_left;
    logic          r_read;
    logic          r_write;
    logic          r_eng_start;
    logic          r_eng_ch;
    logic [DW-1:0] r_eng_in;
    logic [DW-1:0] r_wd_left;
    logic [DW-1:0] r_wd_right;
    logic          r_busy;
    logic          r_timeout_err;
    logic          r_rr_busy_d;
    logic          r_overrun;
`ifdef AUD_FIR_SCHED_BYPASS_EN
    logic          r_bypass;
`endif

    logic          w_waiting;
    logic          w_ctr_clear;
    logic          w_ctr_enable;
    logic          w_expired;
    logic          w_wt_exit;
    logic [DW-1:0] w_wt_result;
    logic          w_rr_busy;

    // One watchdog serves both channels: it is cleared in each start state
    assign w_waiting    = (r_state == S_WT_L) || (r_state == S_WT_R);
    assign w_ctr_clear  = (r_state == S_ST_L) || (r_state == S_ST_R);
    assign w_ctr_enable = w_waiting && !eng_done;

    // A done arriving on the expiry cycle still delivers real data
    assign w_wt_exit    = eng_done || w_expired;
    assign w_wt_result  = eng_done ? eng_out : '0;

    assign w_rr_busy    = read_ready & r_busy;

    sched_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout_ctr (
        .clk       (clock),
        .rst       (reset),
        .i_clear   (w_ctr_clear),
        .i_enable  (w_ctr_enable),
        .o_expired (w_expired)
    );

    // Frame sequencer; every output is set on the edge entering its state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_lat_left    <= '0;
            r_lat_right   <= '0;
            r_res_left    <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_eng_start   <= 1'b0;
            r_eng_ch      <= c_CH_LEFT;
            r_eng_in      <= '0;
            r_wd_left     <= '0;
            r_wd_right    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef AUD_FIR_SCHED_BYPASS_EN
            r_bypass      <= 1'b0;
`endif
        end else begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_eng_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (read_ready) begin
                        r_lat_left  <= readdata_left;
                        r_lat_right <= readdata_right;
`ifdef AUD_FIR_SCHED_BYPASS_EN
                        r_bypass    <= bypass;
`endif
                        r_read      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_RD;
                    end
                end
                S_RD: begin
`ifdef AUD_FIR_SCHED_BYPASS_EN
                    if (r_bypass) begin
                        r_wd_left  <= r_lat_left;
                        r_wd_right <= r_lat_right;
                        r_state    <= S_WR_WAIT;
                    end else begin
                        r_eng_start <= 1'b1;
                        r_eng_ch    <= c_CH_LEFT;
                        r_eng_in    <= r_lat_left;
                        r_state     <= S_ST_L;
                    end
`else
                    r_eng_start <= 1'b1;
                    r_eng_ch    <= c_CH_LEFT;
                    r_eng_in    <= r_lat_left;
                    r_state     <= S_ST_L;
`endif
                end
                S_ST_L: begin
                    r_state <= S_WT_L;
                end
                S_WT_L: begin
                    if (w_wt_exit) begin
                        r_res_left <= w_wt_result;
                        if (!eng_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_eng_start <= 1'b1;
                        r_eng_ch    <= c_CH_RIGHT;
                        r_eng_in    <= r_lat_right;
                        r_state     <= S_ST_R;
                    end
                end
                S_ST_R: begin
                    r_state <= S_WT_R;
                end
                S_WT_R: begin
                    if (w_wt_exit) begin
                        // Right result goes straight to the output register
                        r_wd_left  <= r_res_left;
                        r_wd_right <= w_wt_result;
                        if (!eng_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (write_ready) begin
                        r_write <= 1'b1;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Overrun flags each new frame offered while a frame is in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_busy_d <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rr_busy_d <= w_rr_busy;
            r_overrun   <= w_rr_busy & ~r_rr_busy_d;
        end
    end

    assign read            = r_read;
    assign write           = r_write;
    assign writedata_left  = r_wd_left;
    assign writedata_right = r_wd_right;
    assign eng_start       = r_eng_start;
    assign eng_ch          = r_eng_ch;
    assign eng_in          = r_eng_in;
    assign busy            = r_busy;
    assign timeout_err     = r_timeout_err;
    assign overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_fir_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_fir_scheduler
//  Description : Directed self-checking bench for audio_fir_scheduler with a
//                behavioural FIR engine that returns in+1 after a chosen
//                latency and can withhold done on the right channel.
//  Options     : AUD_FIR_SCHED_BYPASS_EN - also exercises the bypass path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_fir_scheduler;

    localparam int DW      = 24;
    localparam int TIMEOUT = 15;
    localparam int TW      = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          read_ready = 1'b0;
    logic [DW-1:0] readdata_left = '0;
    logic [DW-1:0] readdata_right = '0;
    logic          read;
    logic          write_ready = 1'b0;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    logic          eng_start;
    logic          eng_ch;
    logic [DW-1:0] eng_in;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_out = '0;
`ifdef AUD_FIR_SCHED_BYPASS_EN
    logic          bypass = 1'b0;
`endif
    logic          busy;
    logic          timeout_err;
    logic          overrun;

    audio_fir_scheduler #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .eng_start       (eng_start),
        .eng_ch          (eng_ch),
        .eng_in          (eng_in),
        .eng_done        (eng_done),
        .eng_out         (eng_out),
`ifdef AUD_FIR_SCHED_BYPASS_EN
        .bypass          (bypass),
`endif
        .busy            (busy),
        .timeout_err     (timeout_err),
        .overrun         (overrun)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Engine model: done pulse 'lat' cycles after start, result = in + 1
    int            lat = 3;
    logic          drop_right = 1'b0;
    int            rem = 0;
    logic          pending = 1'b0;
    logic [DW-1:0] pend_in = '0;
    int            n_done = 0;

    always @(negedge clock) begin
        eng_done = 1'b0;
        if (pending) begin
            rem = rem - 1;
            if (rem <= 0) begin
                eng_done = 1'b1;
                eng_out  = pend_in + 24'd1;
                pending  = 1'b0;
                n_done   = n_done + 1;
            end
        end
        if (eng_start && !(drop_right && eng_ch)) begin
            pending = 1'b1;
            rem     = lat;
            pend_in = eng_in;
        end
    end

    // Pulse monitor
    int            n_read = 0;
    int            n_write = 0;
    int            n_start = 0;
    int            n_ovr = 0;
    int            read_cyc = 0;
    int            write_cyc = 0;
    logic          st_ch [0:63];
    logic [DW-1:0] st_in [0:63];

    always @(negedge clock) begin
        if (read) begin
            n_read   = n_read + 1;
            read_cyc = cyc;
        end
        if (write) begin
            n_write   = n_write + 1;
            write_cyc = cyc;
        end
        if (eng_start) begin
            if (n_start < 64) begin
                st_ch[n_start] = eng_ch;
                st_in[n_start] = eng_in;
            end
            n_start = n_start + 1;
        end
        if (overrun) n_ovr = n_ovr + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_reads(input int target, input string tag);
        int k = 0;
        while (n_read < target && k < 400) begin
            tick();
            k++;
        end
        check(tag, 64'(n_read >= target), 64'd1);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int k = 0;
        while (n_write < target && k < 400) begin
            tick();
            k++;
        end
        check(tag, 64'(n_write >= target), 64'd1);
    endtask

    // Offer a frame, wait for its read pulse, withdraw read_ready
    task automatic start_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                               output int rd_lat);
        int c0;
        int r0;
        r0             = n_read;
        readdata_left  = l;
        readdata_right = r;
        read_ready     = 1'b1;
        c0             = cyc;
        wait_reads(r0 + 1, "read_wait");
        read_ready = 1'b0;
        rd_lat     = read_cyc - c0;
    endtask

    initial begin
        int   rl;
        int   w0;
        int   r0;
        int   s0;
        int   d0;
        int   o0;
        int   k;
        int   c;
        logic stable;

        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (3) tick();
        check("rst_outs", {read, write, eng_start, eng_ch, busy, timeout_err, overrun}, 64'd0);
        check("rst_wdata", {writedata_left, writedata_right, eng_in}, 64'd0);
        reset = 1'b0;
        tick();

        // ---------------- basic frame ----------------
        write_ready = 1'b1;
        lat = 3;
        w0 = n_write; r0 = n_read; s0 = n_start;
        start_frame(24'h000100, 24'hFFFF00, rl);
        check("basic_rd_latency", rl, 1);
        wait_writes(w0 + 1, "basic_write_wait");
        repeat (3) tick();
        check("basic_wd_left", writedata_left, 24'h000101);
        check("basic_wd_right", writedata_right, 24'hFFFF01);
        check("basic_write_cnt", n_write - w0, 1);
        check("basic_read_cnt", n_read - r0, 1);
        check("basic_start_cnt", n_start - s0, 2);
        check("basic_ch_seq", {st_ch[s0], st_ch[s0+1]}, 2'b01);
        check("basic_eng_in_l", st_in[s0], 24'h000100);
        check("basic_eng_in_r", st_in[s0+1], 24'hFFFF00);
        check("basic_idle", {busy, timeout_err}, 2'b00);

        // ---------------- minimum latency ----------------
        lat = 1;
        w0 = n_write;
        start_frame(24'h7FFFFF, 24'h800000, rl);
        wait_writes(w0 + 1, "minlat_write_wait");
        check("minlat_rd_to_wr", write_cyc - read_cyc, 6);
        tick();
        check("minlat_wd_left", writedata_left, 24'h800000);
        check("minlat_wd_right", writedata_right, 24'h800001);

        // ---------------- write backpressure ----------------
        write_ready = 1'b0;
        lat = 2;
        w0 = n_write; d0 = n_done;
        start_frame(24'h000200, 24'h000300, rl);
        k = 0;
        while (n_done < d0 + 2 && k < 200) begin
            tick();
            k++;
        end
        check("bp_done_wait", 64'(n_done >= d0 + 2), 64'd1);
        tick();
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (write || writedata_left != 24'h000201 || writedata_right != 24'h000301 || !busy)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_no_write", n_write - w0, 0);
        write_ready = 1'b1;
        c = cyc;
        wait_writes(w0 + 1, "bp_write_wait");
        check("bp_write_delay", write_cyc - c, 1);

        // ---------------- engine timeout on right ----------------
        tick();
        drop_right = 1'b1;
        w0 = n_write;
        start_frame(24'h000010, 24'h000020, rl);
        wait_writes(w0 + 1, "to_write_wait");
        tick();
        check("to_wd_left", writedata_left, 24'h000011);
        check("to_wd_right", writedata_right, 24'h000000);
        check("to_err", timeout_err, 1'b1);
        check("to_write_cnt", n_write - w0, 1);
        drop_right = 1'b0;
        start_frame(24'h000040, 24'h000050, rl);
        wait_writes(w0 + 2, "to2_write_wait");
        tick();
        check("to2_wdata", {writedata_left, writedata_right}, {24'h000041, 24'h000051});
        check("to2_err_sticky", timeout_err, 1'b1);

        // ---------------- overrun ----------------
        lat = 3;
        w0 = n_write; r0 = n_read; o0 = n_ovr;
        start_frame(24'h000400, 24'h000500, rl);
        tick();
        tick();
        readdata_left  = 24'h000600;
        readdata_right = 24'h000700;
        read_ready     = 1'b1;
        wait_writes(w0 + 1, "ovr_write1_wait");
        check("ovr_no_second_read", n_read - r0, 1);
        check("ovr_wd_first", {writedata_left, writedata_right}, {24'h000401, 24'h000501});
        wait_reads(r0 + 2, "ovr_read2_wait");
        read_ready = 1'b0;
        wait_writes(w0 + 2, "ovr_write2_wait");
        tick();
        check("ovr_wd_second", {writedata_left, writedata_right}, {24'h000601, 24'h000701});
        check("ovr_pulses", n_ovr - o0, 1);

        // ---------------- async reset while waiting on right ----------------
        drop_right = 1'b1;
        lat = 1;
        w0 = n_write; s0 = n_start;
        start_frame(24'h000800, 24'h000900, rl);
        k = 0;
        while (n_start < s0 + 2 && k < 100) begin
            tick();
            k++;
        end
        check("ar_right_started", 64'(n_start >= s0 + 2), 64'd1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("ar_outs", {read, write, eng_start, eng_ch, busy, timeout_err, overrun}, 64'd0);
        check("ar_wdata", {writedata_left, writedata_right, eng_in}, 64'd0);
        #1;
        reset = 1'b0;
        drop_right = 1'b0;
        repeat (25) tick();
        check("ar_no_write", n_write - w0, 0);
        start_frame(24'h000A00, 24'h000B00, rl);
        wait_writes(w0 + 1, "ar_write_wait");
        tick();
        check("ar_clean_wdata", {writedata_left, writedata_right}, {24'h000A01, 24'h000B01});
        check("ar_err_clear", timeout_err, 1'b0);

`ifdef AUD_FIR_SCHED_BYPASS_EN
        // ---------------- bypass ----------------
        bypass = 1'b1;
        w0 = n_write; s0 = n_start;
        start_frame(24'h123456, 24'h654321, rl);
        bypass = 1'b0;
        wait_writes(w0 + 1, "byp_write_wait");
        tick();
        check("byp_no_start", n_start - s0, 0);
        check("byp_wd_left", writedata_left, 24'h123456);
        check("byp_wd_right", writedata_right, 24'h654321);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
